// File: rtl/spy_path_launch_capture_if.sv
// Control/status bundle between a run controller and the launch/capture harness.
interface spy_path_launch_capture_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [7:0]       settle_cycles;
  logic [CNT_W-1:0] num_trials;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] rise_err;
  logic [CNT_W-1:0] fall_err;
  logic [CNT_W-1:0] first_err_idx;
  logic             suspect;

  modport master (
    output start, settle_cycles, num_trials,
    input  busy, done, err_count, rise_err, fall_err, first_err_idx, suspect
  );

  modport slave (
    input  start, settle_cycles, num_trials,
    output busy, done, err_count, rise_err, fall_err, first_err_idx, suspect
  );
endinterface

// File: rtl/spy_path_launch_capture.sv
// Launch/capture harness around one instrumented gate chain: toggles the chain input,
// samples the synchronized output after a settle window and accumulates mismatch stats.
module spy_path_launch_capture #(
  parameter bit EXPECT_INVERT = 1'b1,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 16,
  parameter int ERR_THRESH    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  spy_path_launch_capture_if.slave   ctl,
  output logic                       path_in,
  input  logic                       path_out
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PREP    = 3'd1;
  localparam logic [2:0] LAUNCH  = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] FINISH  = 3'd5;

  localparam logic [CNT_W-1:0] ALL1    = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ERR_THRESH);
  localparam logic [8:0]       SYNC_M1 = 9'(SYNC_STAGES - 1);

  logic [2:0]             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             settle_q;
  logic [CNT_W-1:0]       trials_q;
  logic [CNT_W-1:0]       trial_idx;
  logic [CNT_W-1:0]       err_q, rise_q, fall_q, first_q;
  logic [8:0]             wait_cnt;
  logic                   edge_rise;
  logic                   busy_q, done_q, suspect_q;

  // Wait length W-1 where W = max(settle,1) + sync depth; the sync latency is folded in
  // so the sample always sees a value that left the chain at least settle cycles earlier.
  logic [7:0] settle_eff_in, settle_eff_q;
  logic [8:0] w_m1_in, w_m1_q;
  assign settle_eff_in = (ctl.settle_cycles == 8'd0) ? 8'd1 : ctl.settle_cycles;
  assign settle_eff_q  = (settle_q == 8'd0) ? 8'd1 : settle_q;
  assign w_m1_in       = {1'b0, settle_eff_in} + SYNC_M1;
  assign w_m1_q        = {1'b0, settle_eff_q} + SYNC_M1;

  logic sync_out, mismatch;
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign mismatch = sync_out != (path_in ^ EXPECT_INVERT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sync_q    <= '0;
      path_in   <= 1'b0;
      settle_q  <= '0;
      trials_q  <= '0;
      trial_idx <= '0;
      err_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      first_q   <= ALL1;
      wait_cnt  <= '0;
      edge_rise <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      suspect_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], path_out};
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ctl.start) begin
            settle_q  <= ctl.settle_cycles;
            trials_q  <= ctl.num_trials;
            err_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            suspect_q <= 1'b0;
            first_q   <= ALL1;
            trial_idx <= '0;
            busy_q    <= 1'b1;
            if (ctl.num_trials == '0) begin
              state <= FINISH;
            end else begin
              // Precondition low so the first launch is always a rising edge.
              path_in  <= 1'b0;
              wait_cnt <= w_m1_in;
              state    <= PREP;
            end
          end
        end
        PREP: begin
          if (wait_cnt == '0) state <= LAUNCH;
          else                wait_cnt <= wait_cnt - 9'd1;
        end
        LAUNCH: begin
          path_in   <= ~path_in;
          edge_rise <= ~path_in;
          wait_cnt  <= w_m1_q;
          state     <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) state <= CAPTURE;
          else                wait_cnt <= wait_cnt - 9'd1;
        end
        CAPTURE: begin
          if (mismatch) begin
            if (err_q != ALL1) err_q <= err_q + 1'b1;
            if (edge_rise) begin
              if (rise_q != ALL1) rise_q <= rise_q + 1'b1;
            end else begin
              if (fall_q != ALL1) fall_q <= fall_q + 1'b1;
            end
            if (first_q == ALL1) first_q <= trial_idx;
          end
          trial_idx <= trial_idx + 1'b1;
          if (trial_idx + 1'b1 == trials_q) state <= FINISH;
          else                              state <= LAUNCH;
        end
        FINISH: begin
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          suspect_q <= (err_q >= THRESH);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ctl.busy          = busy_q;
  assign ctl.done          = done_q;
  assign ctl.err_count     = err_q;
  assign ctl.rise_err      = rise_q;
  assign ctl.fall_err      = fall_q;
  assign ctl.first_err_idx = first_q;
  assign ctl.suspect       = suspect_q;

endmodule
